sensor_alarm_ctrl: RTL and testbench

- Parametrised N-channel sensor-qualified alarm controller; successor to the fixed 3-sensor buzzer block in the Tiny Tapeout top level.
- Debounces a priority-selected sensor for a programmable number of cycles, then drives a one-hot buzzer for a programmable duration.
- Adds an acknowledge input and a post-alarm hold-off window.
- Instantiated by the top level between ui_in sensor pins and uo_out buzzer pins.

---
 rtl/sensor_alarm_ctrl.sv | 146 ++++++++++++++
 tb/tb_sensor_alarm_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_alarm_ctrl.sv
// sensor_alarm_ctrl: N-channel debounced sensor alarm with timed one-hot buzzer, ack and hold-off.
// Optional build macro SENSOR_ALARM_LATCH_EN: buzzer stays on until ack instead of timing out.
module sensor_alarm_ctrl #(
   parameter int NUM_CH          = 3,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int ALARM_CYCLES    = 32,
   parameter int HOLDOFF_CYCLES  = 4,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_CH-1:0] sensor_in,
   input  logic              ack,
   output logic [NUM_CH-1:0] buzzer_out,
   output logic              alarm_active,
   output logic [CW-1:0]     alarm_ch
);

   localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DW = $clog2(ALARM_CYCLES + 1);
   localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
   localparam logic [QW-1:0] QMAX = QW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DMAX = DW'(ALARM_CYCLES);
   localparam logic [HW-1:0] HMAX = HW'(HOLDOFF_CYCLES);
`ifdef SENSOR_ALARM_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, QUAL, ALARM, HOLD} state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cand, cand_ch, cand_ch_n, ch_n;
   logic              cand_valid, fire, active_n;
   logic [NUM_CH-1:0] cand_hot, buzzer_n;
   logic [QW-1:0]     qual_cnt, qual_n;
   logic [DW-1:0]     dur_cnt, dur_n;
   logic [HW-1:0]     hold_cnt, hold_n;

   // lowest-index asserted sensor wins
   always_comb begin
      cand = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (sensor_in[i]) cand = CW'(i);
   end

   assign cand_valid = |sensor_in;
   assign cand_hot   = NUM_CH'(1) << cand;

   // next-state, counters and registered-output values
   always_comb begin
      state_n   = state;
      cand_ch_n = cand_ch;
      qual_n    = qual_cnt;
      dur_n     = dur_cnt;
      hold_n    = hold_cnt;
      buzzer_n  = buzzer_out;
      active_n  = alarm_active;
      ch_n      = alarm_ch;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            if (cand_valid) begin
               cand_ch_n = cand;
               qual_n    = QW'(1);
               state_n   = QUAL;
               fire      = (QMAX == QW'(1));
            end
         end
         QUAL: begin
            if (!cand_valid) begin
               qual_n  = '0;
               state_n = IDLE;
            end else if (cand != cand_ch) begin
               cand_ch_n = cand;
               qual_n    = QW'(1);
            end else begin
               qual_n = qual_cnt + QW'(1);
               fire   = ((qual_cnt + QW'(1)) == QMAX);
            end
         end
         ALARM: begin
            if (ack || (!LATCH && dur_cnt == DMAX)) begin
               buzzer_n = '0;
               active_n = 1'b0;
               dur_n    = '0;
               hold_n   = '0;
               state_n  = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
            end else if (dur_cnt != DMAX) begin
               dur_n = dur_cnt + DW'(1);
            end
         end
         HOLD: begin
            hold_n = hold_cnt + HW'(1);
            if ((hold_cnt + HW'(1)) == HMAX) begin
               hold_n  = '0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n   = IDLE;
            cand_ch_n = '0;
            qual_n    = '0;
            dur_n     = '0;
            hold_n    = '0;
            buzzer_n  = '0;
            active_n  = 1'b0;
            ch_n      = '0;
         end
      endcase
      if (fire) begin
         state_n  = ALARM;
         qual_n   = '0;
         buzzer_n = cand_hot;
         active_n = 1'b1;
         ch_n     = cand;
         dur_n    = DW'(1);
      end
   end

   // state and output registers; ena low freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cand_ch      <= '0;
         qual_cnt     <= '0;
         dur_cnt      <= '0;
         hold_cnt     <= '0;
         buzzer_out   <= '0;
         alarm_active <= 1'b0;
         alarm_ch     <= '0;
      end else if (ena) begin
         state        <= state_n;
         cand_ch      <= cand_ch_n;
         qual_cnt     <= qual_n;
         dur_cnt      <= dur_n;
         hold_cnt     <= hold_n;
         buzzer_out   <= buzzer_n;
         alarm_active <= active_n;
         alarm_ch     <= ch_n;
      end
   end

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb_sensor_alarm_ctrl: scoreboard bench for sensor_alarm_ctrl with directed test-plan checks.
module tb_sensor_alarm_ctrl;
   localparam int N = 3, D = 8, A = 32, H = 4;
`ifdef SENSOR_ALARM_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic         clk = 1'b0, rst_n = 1'b0, ena = 1'b0, ack = 1'b0;
   logic [N-1:0] sensor_in = '0;
   logic [N-1:0] buzzer_out;
   logic         alarm_active;
   logic [1:0]   alarm_ch;

   sensor_alarm_ctrl #(.NUM_CH(N), .DEBOUNCE_CYCLES(D), .ALARM_CYCLES(A), .HOLDOFF_CYCLES(H)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sensor_in), .ack(ack),
      .buzzer_out(buzzer_out), .alarm_active(alarm_active), .alarm_ch(alarm_ch));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [5:0] exp_q[$];
   int m_mode, m_cnt, m_ch, m_on, m_h;
   logic [N-1:0] m_buz;
   logic m_act;
   logic [1:0] m_ach;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_ch = 0; m_on = 0; m_h = 0;
      m_buz = '0; m_act = 1'b0; m_ach = '0;
   endtask

   task automatic fire(int c);
      m_mode = 2; m_buz = N'(1 << c); m_act = 1'b1; m_ach = 2'(c); m_on = 1;
   endtask

   task automatic model_edge();
      int c;
      if (!rst_n) begin model_reset(); return; end
      if (!ena) return;
      c = -1;
      for (int i = N - 1; i >= 0; i--) if (sensor_in[i]) c = i;
      case (m_mode)
         0: if (c >= 0) begin
               m_ch = c; m_cnt = 1; m_mode = 1;
               if (m_cnt == D) fire(c);
            end
         1: if (c < 0) begin m_cnt = 0; m_mode = 0; end
            else if (c != m_ch) begin m_ch = c; m_cnt = 1; end
            else begin m_cnt++; if (m_cnt == D) fire(c); end
         2: if (ack || (!LATCH && m_on == A)) begin
               m_buz = '0; m_act = 1'b0; m_h = 0; m_mode = (H == 0) ? 0 : 3;
            end else if (m_on < A) m_on++;
         default: begin m_h++; if (m_h == H) m_mode = 0; end
      endcase
   endtask

   task automatic step();
      model_edge();
      exp_q.push_back({m_ach, m_act, m_buz});
      @(posedge clk);
      #1;
      check("sb", 32'({alarm_ch, alarm_active, buzzer_out}), 32'(exp_q.pop_front()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int on, n;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_buz", 32'(buzzer_out), 0);
      check("rst_act", 32'(alarm_active), 0);
      check("rst_ch", 32'(alarm_ch), 0);
      rst_n = 1'b1; ena = 1'b1;

      // T1: ch1 qualifies on edge 8, on for 32 cycles
      sensor_in = 3'b010;
      repeat (7) step();
      check("t1_pre", 32'(buzzer_out), 0);
      step();
      check("t1_buz", 32'(buzzer_out), 32'b010);
      check("t1_act", 32'(alarm_active), 1);
      check("t1_ch", 32'(alarm_ch), 1);
      sensor_in = '0;
`ifdef SENSOR_ALARM_LATCH_EN
      repeat (100) step();
      check("latch_hold", 32'(buzzer_out), 32'b010);
      ack = 1'b1; step(); ack = 1'b0;
      check("latch_ack", 32'(buzzer_out), 0);
`else
      on = 1;
      for (int k = 0; k < 60 && buzzer_out != 0; k++) begin step(); if (buzzer_out != 0) on++; end
      check("t1_on", on, A);
`endif
      repeat (8) step();

      // T2: higher-priority sensor restarts qualification
      sensor_in = 3'b100;
      repeat (5) step();
      sensor_in = 3'b101;
      repeat (7) step();
      check("t2_pre", 32'(buzzer_out), 0);
      step();
      check("t2_buz", 32'(buzzer_out), 32'b001);
      check("t2_ch", 32'(alarm_ch), 0);
      sensor_in = '0;
      ack = 1'b1; step(); ack = 1'b0;
      repeat (8) step();

      // T3: a one-cycle dropout resets the debounce
      sensor_in = 3'b001;
      repeat (7) step();
      sensor_in = '0; step();
      sensor_in = 3'b001;
      repeat (7) step();
      check("t3_pre", 32'(buzzer_out), 0);
      step();
      check("t3_buz", 32'(buzzer_out), 32'b001);

      // T4: ack at dur_cnt=10, hold-off 4, re-alarm 8 later
      repeat (9) step();
      ack = 1'b1; step(); ack = 1'b0;
      check("t4_ack", 32'(buzzer_out), 0);
      n = 0;
      for (int k = 0; k < 30 && buzzer_out == 0; k++) begin step(); n++; end
      check("t4_rearm", n, H + D);

      // T5: ena low freezes alarm, then async reset mid-alarm
      repeat (4) step();
      ena = 1'b0;
      repeat (20) step();
      check("t5_frozen", 32'(buzzer_out), 32'b001);
      ena = 1'b1;
`ifdef SENSOR_ALARM_LATCH_EN
      ack = 1'b1; step(); ack = 1'b0;
      check("t5_ack", 32'(buzzer_out), 0);
`else
      on = 5;
      for (int k = 0; k < 60 && buzzer_out != 0; k++) begin step(); if (buzzer_out != 0) on++; end
      check("t5_on", on, A);
`endif
      sensor_in = 3'b010;
      for (int k = 0; k < 30 && buzzer_out == 0; k++) step();
      check("t5_ch1", 32'(alarm_ch), 1);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_buz", 32'(buzzer_out), 0);
      check("arst_act", 32'(alarm_active), 0);
      check("arst_ch", 32'(alarm_ch), 0);
      model_reset();
      sensor_in = '0;
      #3 rst_n = 1'b1;
      repeat (2) step();
      sensor_in = 3'b010;
      repeat (8) step();
      check("post_rst_buz", 32'(buzzer_out), 32'b010);
      sensor_in = '0;
      ack = 1'b1; step(); ack = 1'b0;

      // T6: random traffic against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) sensor_in = N'($urandom_range(0, 7));
         ack = ($urandom_range(0, 39) == 0);
         ena = ($urandom_range(0, 7) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
